// File: rtl/byte_to_burst.sv
// rtl/byte_to_burst.sv - DDR read-path byte lane deserializer assembling 2/4/8-byte bursts into 64-bit words

package type_pkg;
   typedef enum logic [1:0] {
      TWO_BYTES   = 2'b00,
      FOUR_BYTES  = 2'b01,
      EIGHT_BYTES = 2'b10
   } burst_size_t;

   typedef enum logic [2:0] {
      RIDLE,
      RWAIT,
      RBURST12,
      RBURST4,
      RBURST6,
      RBURST8
   } read_burst_states_t;
endpackage

module byte_to_burst
   import type_pkg::*;
#(
   parameter int unsigned READ_LAT = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        rd_start,
   input  burst_size_t rburst_size,
   input  logic        r_dqs,
   input  logic [7:0]  ddr_byte,
   output logic [63:0] rdata,
   output logic        rdata_valid,
   output burst_size_t rdata_size,
   output logic        rdata_err,
   output logic        rd_busy,
   output logic        rd_overrun
);

   localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

   read_burst_states_t state_q, state_d;
   burst_size_t        size_q, size_norm;
   logic [3:0]         lat_q;
   logic [63:0]        asm_q, asm_d;
   logic               err_q;
   logic [7:0]         lo_q;
   logic               dqs_q;

   logic               in_beat, last_beat, accept, reject;
   logic [1:0]         beat_idx;

   // Unknown size encodings fall back to the single-beat burst.
   always_comb begin
      case (rburst_size)
         FOUR_BYTES:  size_norm = FOUR_BYTES;
         EIGHT_BYTES: size_norm = EIGHT_BYTES;
         default:     size_norm = TWO_BYTES;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= RIDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_beat   = 1'b0;
      last_beat = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      beat_idx  = 2'd0;
      case (state_q)
         RIDLE: begin
            if (rd_start) begin
               accept  = 1'b1;
               state_d = RWAIT;
            end
         end
         RWAIT: begin
            reject = rd_start;
            if (lat_q == 4'd0) state_d = RBURST12;
         end
         RBURST12: begin
            in_beat  = 1'b1;
            beat_idx = 2'd0;
            if (size_q == FOUR_BYTES || size_q == EIGHT_BYTES) state_d = RBURST4;
            else last_beat = 1'b1;
         end
         RBURST4: begin
            in_beat  = 1'b1;
            beat_idx = 2'd1;
            if (size_q == EIGHT_BYTES) state_d = RBURST6;
            else last_beat = 1'b1;
         end
         RBURST6: begin
            in_beat  = 1'b1;
            beat_idx = 2'd2;
            state_d  = RBURST8;
         end
         RBURST8: begin
            in_beat   = 1'b1;
            beat_idx  = 2'd3;
            last_beat = 1'b1;
         end
         default: state_d = RIDLE;
      endcase
      if (in_beat && !last_beat) reject = rd_start;
      if (last_beat) begin
         accept  = rd_start;
         state_d = rd_start ? RWAIT : RIDLE;
      end
   end

   // Low byte comes from the negedge register, high byte is on the lane at the closing posedge.
   always_comb begin
      asm_d = asm_q;
      asm_d[{beat_idx, 4'b0000} +: 16] = {ddr_byte, lo_q};
   end

   always_ff @(negedge clk or negedge n_rst) begin
      if (!n_rst) begin
         lo_q  <= 8'h00;
         dqs_q <= 1'b0;
      end else begin
         lo_q  <= ddr_byte;
         dqs_q <= r_dqs;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         size_q      <= TWO_BYTES;
         lat_q       <= 4'd0;
         asm_q       <= 64'd0;
         err_q       <= 1'b0;
         rdata       <= 64'd0;
         rdata_valid <= 1'b0;
         rdata_size  <= TWO_BYTES;
         rdata_err   <= 1'b0;
         rd_overrun  <= 1'b0;
      end else begin
         rdata_valid <= last_beat;
         rd_overrun  <= reject;
         if (state_q == RWAIT && lat_q != 4'd0) lat_q <= lat_q - 4'd1;
         if (in_beat) begin
            asm_q <= asm_d;
            if (!dqs_q) err_q <= 1'b1;
         end
         if (last_beat) begin
            rdata      <= asm_d;
            rdata_size <= size_q;
            rdata_err  <= err_q | ~dqs_q;
         end
         // A newly accepted burst overrides the beat update of a finishing one.
         if (accept) begin
            size_q <= size_norm;
            asm_q  <= 64'd0;
            err_q  <= 1'b0;
            lat_q  <= LAT_LOAD;
         end
      end
   end

   assign rd_busy = (state_q != RIDLE);

endmodule

// File: tb/tb_byte_to_burst.sv
// tb/tb_byte_to_burst.sv - randomized and directed bench for byte_to_burst against a cycle-indexed burst model

module tb_byte_to_burst;
   import type_pkg::*;

   localparam int L = 2;
   localparam int N = 2048;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        rd_start = 1'b0;
   burst_size_t rburst_size = TWO_BYTES;
   logic        r_dqs = 1'b0;
   logic [7:0]  ddr_byte = 8'h00;
   logic [63:0] rdata;
   logic        rdata_valid;
   burst_size_t rdata_size;
   logic        rdata_err;
   logic        rd_busy;
   logic        rd_overrun;

   byte_to_burst #(.READ_LAT(L)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .rd_start    (rd_start),
      .rburst_size (rburst_size),
      .r_dqs       (r_dqs),
      .ddr_byte    (ddr_byte),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .rdata_size  (rdata_size),
      .rdata_err   (rdata_err),
      .rd_busy     (rd_busy),
      .rd_overrun  (rd_overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int busy_end = 0;

   // Model: per-cycle beat schedule and per-cycle expected outputs.
   bit [7:0]    b_lo [N];
   bit [7:0]    b_hi [N];
   bit          b_on [N];
   bit          b_dqs[N];
   bit          e_valid[N];
   bit          e_ovr[N];
   bit          e_err[N];
   bit [63:0]   e_data[N];
   bit [1:0]    e_size[N];
   logic [63:0] last_rdata = 64'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int beats_of(input burst_size_t s);
      case (s)
         EIGHT_BYTES: return 4;
         FOUR_BYTES:  return 2;
         default:     return 1;
      endcase
   endfunction

   task automatic step(input logic start, input burst_size_t sz, input bit use_pat,
                       input logic [63:0] pat, input logic [3:0] dqs_ok);
      int e;
      int n;
      logic [63:0] d;
      bit err;
      logic [7:0] lo, hi;
      rd_start    = start;
      rburst_size = sz;
      @(posedge clk);
      cyc++;
      e = cyc;
      if (start && n_rst) begin
         if (e >= busy_end) begin
            n = beats_of(sz);
            d = 64'd0;
            err = 1'b0;
            for (int k = 0; k < n; k++) begin
               lo = use_pat ? pat[16*k +: 8] : 8'($urandom);
               hi = use_pat ? pat[16*k+8 +: 8] : 8'($urandom);
               b_on [e+L+k] = 1'b1;
               b_lo [e+L+k] = lo;
               b_hi [e+L+k] = hi;
               b_dqs[e+L+k] = dqs_ok[k];
               d[16*k +: 16] = {hi, lo};
               if (!dqs_ok[k]) err = 1'b1;
            end
            e_valid[e+L+n] = 1'b1;
            e_data [e+L+n] = d;
            e_err  [e+L+n] = err;
            e_size [e+L+n] = (n == 4) ? 2'b10 : (n == 2) ? 2'b01 : 2'b00;
            busy_end = e + L + n;
         end else begin
            e_ovr[e] = 1'b1;
         end
      end
      #1;
      if (e_valid[e]) last_rdata = e_data[e];
      chk("rdata_valid", 64'(rdata_valid), 64'(e_valid[e]));
      chk("rd_overrun", 64'(rd_overrun), 64'(e_ovr[e]));
      chk("rd_busy", 64'(rd_busy), 64'(e < busy_end));
      chk("rdata", rdata, last_rdata);
      if (e_valid[e]) begin
         chk("rdata_size", 64'(rdata_size), 64'(e_size[e]));
         chk("rdata_err", 64'(rdata_err), 64'(e_err[e]));
      end
      if (b_on[e]) begin
         ddr_byte = b_lo[e];
         r_dqs    = b_dqs[e];
      end else begin
         ddr_byte = 8'($urandom);
         r_dqs    = 1'($urandom);
      end
      @(negedge clk);
      #1;
      ddr_byte = b_on[e] ? b_hi[e] : 8'($urandom);
      r_dqs    = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, TWO_BYTES, 1'b0, 64'd0, 4'hF);
   endtask

   task automatic reset_now();
      n_rst = 1'b0;
      #1;
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_valid", 64'(rdata_valid), 64'd0);
      chk("rst_err", 64'(rdata_err), 64'd0);
      chk("rst_busy", 64'(rd_busy), 64'd0);
      chk("rst_overrun", 64'(rd_overrun), 64'd0);
      chk("rst_size", 64'(rdata_size), 64'(TWO_BYTES));
      for (int i = cyc + 1; i < N; i++) begin
         b_on[i] = 1'b0;
         e_valid[i] = 1'b0;
         e_ovr[i] = 1'b0;
      end
      busy_end = 0;
      last_rdata = 64'd0;
   endtask

   initial begin
      burst_size_t rs;
      logic [3:0] rm;
      reset_now();
      idle(2);
      n_rst = 1'b1;
      idle(2);

      step(1'b1, EIGHT_BYTES, 1'b1, 64'h0807060504030201, 4'hF);
      idle(L + 5);

      step(1'b1, TWO_BYTES, 1'b1, 64'h000000000000BBAA, 4'hF);
      idle(L + 2);

      step(1'b1, FOUR_BYTES, 1'b1, 64'h00000000DDCCBBAA, 4'hF);
      idle(L + 1);
      step(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 4'hF);
      idle(L + 5);

      step(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 4'b1011);
      idle(L + 5);
      step(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 4'hF);
      idle(L + 5);

      step(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 4'hF);
      step(1'b1, FOUR_BYTES, 1'b0, 64'd0, 4'hF);
      idle(2);
      step(1'b1, TWO_BYTES, 1'b0, 64'd0, 4'hF);
      idle(L + 4);

      step(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 4'hF);
      idle(4);
      reset_now();
      idle(2);
      n_rst = 1'b1;
      idle(1);
      step(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 4'hF);
      idle(L + 5);

      for (int i = 0; i < 300; i++) begin
         rs = burst_size_t'(2'($urandom % 3));
         rm = ($urandom % 5 == 0) ? 4'($urandom) : 4'hF;
         step(($urandom % 3) == 0, rs, 1'b0, 64'd0, rm);
      end
      idle(L + 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
